// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch-stage program-counter unit: branch signals,
// condition codes, flag bit positions and the run/halt state type.
package pc_defs;

   localparam logic [1:0] BSIG_SEQ = 2'b00;
   localparam logic [1:0] BSIG_B   = 2'b01;
   localparam logic [1:0] BSIG_BR  = 2'b10;
   localparam logic [1:0] BSIG_HLT = 2'b11;

   localparam logic [2:0] COND_NE = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_GT = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_GE = 3'b100;
   localparam logic [2:0] COND_LE = 3'b101;
   localparam logic [2:0] COND_VS = 3'b110;
   localparam logic [2:0] COND_AL = 3'b111;

   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_Z = 0;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// Combinational condition evaluator: condition code plus {N,V,Z} flags to a
// taken decision. Kept standalone so decode/hazard logic can reuse it.
module branch_cond
   import pc_defs::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] flags,
   output logic       taken
);

   logic n_s;
   logic v_s;
   logic z_s;

   assign n_s = flags[FLAG_N];
   assign v_s = flags[FLAG_V];
   assign z_s = flags[FLAG_Z];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_NE: taken = ~z_s;
         COND_EQ: taken = z_s;
         COND_GT: taken = ~z_s & ~n_s;
         COND_LT: taken = n_s;
         COND_GE: taken = z_s | (~z_s & ~n_s);
         COND_LE: taken = n_s | z_s;
         COND_VS: taken = v_s;
         COND_AL: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: next-PC selection, flag-wait handling,
// RUN/HALT state, one-cycle redirect flush and a saturating taken-branch counter.
module pc_sequencer
   import pc_defs::*;
#(
   parameter int unsigned PC_W     = 16,
   parameter int unsigned IMM_W    = 10,
   parameter int unsigned BR_SHIFT = 0,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             instr_valid,
   input  logic [1:0]       bsig,
   input  logic [2:0]       cond,
   input  logic [2:0]       flags,
   input  logic             flags_valid,
   input  logic [IMM_W-1:0] imm,
   input  logic [PC_W-1:0]  regsrc,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  pc_next,
   output logic             flush,
   output logic             halted,
   output logic             branch_wait,
   output logic [CNT_W-1:0] taken_cnt
);

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             flush_q, flush_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             taken_s;
   logic             active_s;
   logic             is_branch_s;
   logic             wait_s;
   logic             advance_s;
   logic             redirect_s;
   logic [PC_W-1:0]  seq_s;
   logic [PC_W-1:0]  offset_s;
   logic [PC_W-1:0]  reg_tgt_s;

   branch_cond u_branch_cond (
      .cond  (cond),
      .flags (flags),
      .taken (taken_s)
   );

   assign seq_s       = pc_q + PC_W'(2);
   assign offset_s    = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm} << BR_SHIFT;
   // Register targets are halfword aligned; the low bit of regsrc is discarded.
   assign reg_tgt_s   = regsrc & ~PC_W'(1);
   assign active_s    = (state_q == ST_RUN) & instr_valid & ~stall;
   assign is_branch_s = (bsig == BSIG_B) | (bsig == BSIG_BR);
   assign wait_s      = active_s & is_branch_s & (cond != COND_AL) & ~flags_valid;
   assign advance_s   = active_s & ~wait_s;
   assign redirect_s  = advance_s & is_branch_s & taken_s;

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      flush_d = 1'b0;
      cnt_d   = cnt_q;
      if (advance_s) begin
         case (bsig)
            BSIG_SEQ: pc_d = seq_s;
            BSIG_B:   pc_d = taken_s ? (seq_s + offset_s) : seq_s;
            BSIG_BR:  pc_d = taken_s ? reg_tgt_s : seq_s;
            BSIG_HLT: state_d = ST_HALT;
            default:  pc_d = pc_q;
         endcase
      end else begin
         pc_d = pc_q;
      end
      if (redirect_s) begin
         flush_d = 1'b1;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         flush_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= ST_RUN;
         flush_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         flush_q <= flush_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc          = pc_q;
   assign pc_next     = pc_d;
   assign flush       = flush_q;
   assign halted      = (state_q == ST_HALT);
   assign branch_wait = wait_s;
   assign taken_cnt   = cnt_q;

endmodule
